mem_bus_arbiter: RTL and testbench

Two-master arbiter and sequencer for the picorv32 native memory bus. It shares one slave-side bus (on-chip RAM plus the UART, LED and other decoded peripherals) between the CPU (master 0) and a debug/loader master (master 1). It also gates transaction completion for run/single-step control and terminates hung transactions with a timeout. It sits between the CPU/loader and the existing address decode.

---
 rtl/mem_bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the picorv32 native bus: round-robin grant, run/step gating
// of completions, and a watchdog that terminates hung transactions with ERR_DATA.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  input  logic        run,
  input  logic        step,
  input  logic        err_clr,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam logic [31:0] TMO_LIMIT = TIMEOUT_CYCLES;
  localparam logic        TMO_EN    = (TIMEOUT_CYCLES != 0);

  state_t      state, state_next;
  logic        last_grant, last_grant_next;
  logic        step_armed;
  logic [31:0] timer;
  logic        timeout_reg;

  logic        granted;
  logic        cur_valid;
  logic        counting;
  logic        timeout_hit;
  logic        complete;
  logic        xfer_done;
  logic [31:0] resp_data;

  // Timeout is decided from the timer alone so s_valid never depends on s_ready.
  always_comb begin
    granted     = (state != IDLE);
    cur_valid   = 1'b0;
    case (state)
      GNT0:    cur_valid = m0_valid;
      GNT1:    cur_valid = m1_valid;
      default: cur_valid = 1'b0;
    endcase
    counting    = run | step_armed;
    timeout_hit = TMO_EN & granted & cur_valid & counting & (timer == TMO_LIMIT);
    complete    = granted & cur_valid & s_ready & counting & ~timeout_hit;
    xfer_done   = complete | timeout_hit;
    resp_data   = timeout_hit ? ERR_DATA : s_rdata;
  end

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    s_valid         = 1'b0;
    s_instr         = 1'b0;
    s_addr          = 32'h0;
    s_wdata         = 32'h0;
    s_wstrb         = 4'h0;
    m0_ready        = 1'b0;
    m0_rdata        = 32'h0;
    m1_ready        = 1'b0;
    m1_rdata        = 32'h0;
    case (state)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          if (last_grant) begin
            state_next      = GNT0;
            last_grant_next = 1'b0;
          end else begin
            state_next      = GNT1;
            last_grant_next = 1'b1;
          end
        end else if (m0_valid) begin
          state_next      = GNT0;
          last_grant_next = 1'b0;
        end else if (m1_valid) begin
          state_next      = GNT1;
          last_grant_next = 1'b1;
        end
      end
      GNT0: begin
        s_valid  = m0_valid & ~timeout_hit;
        s_instr  = m0_instr;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = m0_wstrb;
        m0_ready = xfer_done;
        m0_rdata = xfer_done ? resp_data : 32'h0;
        if (!m0_valid || xfer_done) state_next = IDLE;
      end
      GNT1: begin
        s_valid  = m1_valid & ~timeout_hit;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_wstrb  = m1_wstrb;
        m1_ready = xfer_done;
        m1_rdata = xfer_done ? resp_data : 32'h0;
        if (!m1_valid || xfer_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  // A pulse arriving in the completing cycle is dropped, so pulses never queue up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_armed <= 1'b0;
    end else if (xfer_done) begin
      step_armed <= 1'b0;
    end else if (step) begin
      step_armed <= 1'b1;
    end
  end

  // Held at zero while idle, so every grant starts counting from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= 32'h0;
    end else if (state == IDLE) begin
      timer <= 32'h0;
    end else if (TMO_EN && cur_valid && counting && !xfer_done) begin
      timer <= timer + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_reg <= 1'b0;
    end else if (timeout_hit) begin
      timeout_reg <= 1'b1;
    end else if (err_clr) begin
      timeout_reg <= 1'b0;
    end
  end

  assign grant       = state;
  assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; responses are checked against a scoreboard
// filled at stimulus time and drained whenever either master sees ready.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m0_instr, m0_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic        m1_valid, m1_ready;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic        s_valid, s_instr, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        run, step, err_clr;
  logic [1:0]  grant;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        master;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cont_grant[7] = '{0, 1, 0, 2, 0, 1, 0};

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .run(run), .step(step), .err_clr(err_clr),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic v1, input logic sr, input logic [31:0] rd);
    m0_valid = v0;
    m1_valid = v1;
    s_ready  = sr;
    s_rdata  = rd;
  endtask

  task automatic expect_resp(input logic master, input logic [31:0] data);
    exp_t e;
    e.master = master;
    e.data   = data;
    sb.push_back(e);
  endtask

  // Inputs change just after the rising edge; everything is sampled mid-low-phase.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #5;
  endtask

  always @(negedge clk) begin
    #1;
    if (m0_ready === 1'b1 || m1_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("[TB] FAIL sb_underflow observed=ready expected=no_response");
      end else begin
        mon_e = sb.pop_front();
        checkOutput("sb_master", {30'b0, m1_ready, m0_ready}, mon_e.master ? 32'd2 : 32'd1);
        checkOutput("sb_rdata", mon_e.master ? m1_rdata : m0_rdata, mon_e.data);
      end
    end
    if (grant !== 2'b01) begin
      checkOutput("m0_ready_ungranted", {31'b0, m0_ready}, 32'd0);
      checkOutput("m0_rdata_ungranted", m0_rdata, 32'd0);
    end
    if (grant !== 2'b10) begin
      checkOutput("m1_ready_ungranted", {31'b0, m1_ready}, 32'd0);
      checkOutput("m1_rdata_ungranted", m1_rdata, 32'd0);
    end
  end

  initial begin
    reset    = 1'b1;
    run      = 1'b1;
    step     = 1'b0;
    err_clr  = 1'b0;
    m0_instr = 1'b1;
    m0_addr  = 32'h0000_1000;
    m0_wdata = 32'h0;
    m0_wstrb = 4'h0;
    m1_addr  = 32'h0000_2000;
    m1_wdata = 32'h0;
    m1_wstrb = 4'h0;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hA000_0000);

    // Reset holds everything quiet even with both masters requesting.
    repeat (2) tick();
    settle();
    checkOutput("rst_grant", {30'b0, grant}, 32'd0);
    checkOutput("rst_s_valid", {31'b0, s_valid}, 32'd0);
    checkOutput("rst_m0_ready", {31'b0, m0_ready}, 32'd0);
    checkOutput("rst_m1_ready", {31'b0, m1_ready}, 32'd0);
    checkOutput("rst_timeout_err", {31'b0, timeout_err}, 32'd0);

    // Contention straight out of reset: m0 first, then strict alternation.
    for (int n = 0; n < 7; n++) begin
      tick();
      if (n == 0) reset = 1'b0;
      s_rdata = 32'hA000_0000 + 32'(n);
      if (n == 6) applyStimulus(1'b0, 1'b0, 1'b1, s_rdata);
      if (cont_grant[n] == 1) expect_resp(1'b0, s_rdata);
      if (cont_grant[n] == 2) expect_resp(1'b1, s_rdata);
      settle();
      checkOutput("cont_grant", {30'b0, grant}, 32'(cont_grant[n]));
      if (cont_grant[n] == 1) begin
        checkOutput("cont_s_addr_m0", s_addr, 32'h0000_1000);
        checkOutput("cont_s_instr_m0", {31'b0, s_instr}, 32'd1);
      end
      if (cont_grant[n] == 2) begin
        checkOutput("cont_s_addr_m1", s_addr, 32'h0000_2000);
        checkOutput("cont_s_instr_m1", {31'b0, s_instr}, 32'd0);
      end
    end

    // Single read completing in the first granted cycle.
    tick();
    m0_addr  = 32'h0000_0100;
    m0_instr = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h1234_5678);
    expect_resp(1'b0, 32'h1234_5678);
    settle();
    checkOutput("rd_idle_grant", {30'b0, grant}, 32'd0);
    checkOutput("rd_idle_s_valid", {31'b0, s_valid}, 32'd0);
    tick();
    settle();
    checkOutput("rd_grant", {30'b0, grant}, 32'd1);
    checkOutput("rd_s_valid", {31'b0, s_valid}, 32'd1);
    checkOutput("rd_s_addr", s_addr, 32'h0000_0100);
    checkOutput("rd_m0_ready", {31'b0, m0_ready}, 32'd1);
    checkOutput("rd_m0_rdata", m0_rdata, 32'h1234_5678);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("rd_after_grant", {30'b0, grant}, 32'd0);

    // Step mode: halted fetch, single step, then two pulses giving one completion.
    tick();
    run      = 1'b0;
    m0_instr = 1'b1;
    m0_addr  = 32'h0000_0200;
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hCAFE_0001);
    expect_resp(1'b0, 32'hCAFE_0001);
    settle();
    for (int i = 0; i < 20; i++) begin
      tick();
      settle();
      checkOutput("halt_m0_ready", {31'b0, m0_ready}, 32'd0);
      checkOutput("halt_grant", {30'b0, grant}, 32'd1);
    end
    tick();
    step = 1'b1;
    settle();
    checkOutput("step_pulse_cycle", {31'b0, m0_ready}, 32'd0);
    tick();
    step = 1'b0;
    settle();
    checkOutput("step_ready", {31'b0, m0_ready}, 32'd1);
    checkOutput("step_rdata", m0_rdata, 32'hCAFE_0001);
    tick();
    m0_addr = 32'h0000_0204;
    s_rdata = 32'hCAFE_0002;
    expect_resp(1'b0, 32'hCAFE_0002);
    settle();
    checkOutput("step_idle_grant", {30'b0, grant}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      settle();
      checkOutput("step2_stall", {31'b0, m0_ready}, 32'd0);
    end
    tick();
    step = 1'b1;
    settle();
    checkOutput("dbl_first_pulse", {31'b0, m0_ready}, 32'd0);
    tick();
    settle();
    checkOutput("dbl_ready", {31'b0, m0_ready}, 32'd1);
    tick();
    step    = 1'b0;
    m0_addr = 32'h0000_0208;
    s_rdata = 32'hCAFE_0003;
    expect_resp(1'b0, 32'hCAFE_0003);
    settle();
    for (int i = 0; i < 6; i++) begin
      tick();
      settle();
      checkOutput("dbl_no_accum", {31'b0, m0_ready}, 32'd0);
    end
    tick();
    run = 1'b1;
    settle();
    checkOutput("run_resume_ready", {31'b0, m0_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    settle();

    // Timeout on an unmapped write: fires when timer reaches 4.
    tick();
    m1_addr  = 32'hF000_0000;
    m1_wdata = 32'h1111_2222;
    m1_wstrb = 4'hF;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0BAD_0BAD);
    expect_resp(1'b1, 32'hDEAD_BEEF);
    settle();
    for (int i = 0; i < 4; i++) begin
      tick();
      settle();
      checkOutput("tmo_wait_grant", {30'b0, grant}, 32'd2);
      checkOutput("tmo_wait_s_valid", {31'b0, s_valid}, 32'd1);
      checkOutput("tmo_wait_ready", {31'b0, m1_ready}, 32'd0);
    end
    checkOutput("tmo_s_wstrb", {28'b0, s_wstrb}, 32'hF);
    tick();
    settle();
    checkOutput("tmo_ready", {31'b0, m1_ready}, 32'd1);
    checkOutput("tmo_rdata", m1_rdata, 32'hDEAD_BEEF);
    checkOutput("tmo_s_valid", {31'b0, s_valid}, 32'd0);
    checkOutput("tmo_err_not_yet", {31'b0, timeout_err}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("tmo_idle", {30'b0, grant}, 32'd0);
    checkOutput("tmo_err_set", {31'b0, timeout_err}, 32'd1);
    tick();
    err_clr = 1'b1;
    settle();
    checkOutput("tmo_err_held", {31'b0, timeout_err}, 32'd1);
    tick();
    err_clr = 1'b0;
    settle();
    checkOutput("tmo_err_cleared", {31'b0, timeout_err}, 32'd0);

    // A new timeout coincident with err_clr must leave the flag set.
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    expect_resp(1'b1, 32'hDEAD_BEEF);
    settle();
    for (int i = 0; i < 4; i++) begin
      tick();
      settle();
      checkOutput("tmo2_wait_ready", {31'b0, m1_ready}, 32'd0);
    end
    tick();
    err_clr = 1'b1;
    settle();
    checkOutput("tmo2_ready", {31'b0, m1_ready}, 32'd1);
    tick();
    err_clr = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("tmo2_set_wins", {31'b0, timeout_err}, 32'd1);
    tick();
    err_clr = 1'b1;
    settle();
    tick();
    err_clr = 1'b0;
    settle();
    checkOutput("tmo2_cleared", {31'b0, timeout_err}, 32'd0);

    // Halted write with no slave response never times out; then valid is withdrawn.
    tick();
    run      = 1'b0;
    m1_wstrb = 4'h0;
    m0_addr  = 32'hF000_0004;
    m0_wstrb = 4'hF;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    for (int i = 0; i < 50; i++) begin
      tick();
      settle();
      checkOutput("halt_no_tmo_err", {31'b0, timeout_err}, 32'd0);
      checkOutput("halt_no_tmo_ready", {31'b0, m0_ready}, 32'd0);
    end
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("drop_valid_ready", {31'b0, m0_ready}, 32'd0);
    checkOutput("drop_valid_s_valid", {31'b0, s_valid}, 32'd0);
    tick();
    settle();
    checkOutput("drop_valid_idle", {30'b0, grant}, 32'd0);
    checkOutput("drop_valid_no_err", {31'b0, timeout_err}, 32'd0);

    // Reset in the middle of an m1 transaction, then m0 must win first again.
    tick();
    run      = 1'b1;
    m0_wstrb = 4'h0;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    settle();
    tick();
    settle();
    checkOutput("mid_grant_m1", {30'b0, grant}, 32'd2);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_grant", {30'b0, grant}, 32'd0);
    checkOutput("mid_rst_s_valid", {31'b0, s_valid}, 32'd0);
    checkOutput("mid_rst_m1_ready", {31'b0, m1_ready}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h5A5A_5A5A);
    expect_resp(1'b0, 32'h5A5A_5A5A);
    tick();
    reset = 1'b0;
    settle();
    checkOutput("post_rst_idle", {30'b0, grant}, 32'd0);
    tick();
    settle();
    checkOutput("post_rst_m0_first", {30'b0, grant}, 32'd1);
    checkOutput("post_rst_m0_ready", {31'b0, m0_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("post_rst_idle2", {30'b0, grant}, 32'd0);
    tick();
    settle();
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
